// File: rtl/uart_echo_pkg.sv
// Shared types and helpers for the UART echo queue: mode encodings, line-ending
// bytes, transmit FSM states and the per-byte case transform.
package uart_echo_pkg;

   localparam logic [1:0] MODE_PASS  = 2'b00;
   localparam logic [1:0] MODE_UPPER = 2'b01;
   localparam logic [1:0] MODE_LOWER = 2'b10;
   localparam logic [1:0] MODE_SWAP  = 2'b11;

   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;
   localparam logic [7:0] CASE_DELTA = 8'h20;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_REQ,
      ST_WAIT
   } tx_state_t;

   function automatic logic [7:0] case_convert(input logic [7:0] c, input logic [1:0] mode);
      logic is_lower;
      logic is_upper;
      logic [7:0] result;
      is_lower = (c >= 8'h61) && (c <= 8'h7A);
      is_upper = (c >= 8'h41) && (c <= 8'h5A);
      result   = c;
      case (mode)
         MODE_PASS:  result = c;
         MODE_UPPER: if (is_lower) result = c - CASE_DELTA;
         MODE_LOWER: if (is_upper) result = c + CASE_DELTA;
         MODE_SWAP: begin
            if (is_lower)      result = c - CASE_DELTA;
            else if (is_upper) result = c + CASE_DELTA;
         end
         default:    result = c;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/uart_echo_queue_fifo.sv
// Small string queue: DEPTH entries of {length, string}, head-of-queue read is
// combinational so the transmit FSM can register it straight into its outputs.
module uart_echo_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wr_data,
   output logic [W-1:0]             rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (pop)  head_d = head_q + PTR_W'(1);
      if (push) tail_d = tail_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage is left unreset so it maps onto plain RAM; the pointers define validity.
   always_ff @(posedge sys_clk) begin
      if (push) mem[tail_q] <= wr_data;
   end

   assign rd_data = mem[head_q];
   assign count   = count_q;

endmodule

// File: rtl/uart_echo_queue.sv
// Echo engine: transforms each received string, queues it, and replays queued
// strings through the transmitter request/done handshake with a timeout.
module uart_echo_queue
   import uart_echo_pkg::*;
#(
   parameter int MAX_LEN     = 128,
   parameter int LEN_W       = 8,
   parameter int DEPTH       = 2,
   parameter int APPEND_CRLF = 1,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic [1:0]                 mode,
   input  logic [MAX_LEN*8-1:0]       rx_string,
   input  logic [LEN_W-1:0]           rx_length,
   input  logic                       rx_done,
   output logic [MAX_LEN*8-1:0]       tx_string,
   output logic [LEN_W-1:0]           tx_length,
   output logic                       tx_req,
   input  logic                       tx_busy,
   input  logic                       tx_done,
   output logic [$clog2(DEPTH):0]     q_count,
   output logic [7:0]                 drop_cnt,
   output logic                       timeout_err
);

   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int SW      = MAX_LEN * 8;
   localparam int ENTRY_W = SW + LEN_W;
   localparam int TMR_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [LEN_W-1:0] CAP_LEN  = LEN_W'((APPEND_CRLF != 0) ? MAX_LEN - 2 : MAX_LEN);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   // ---------------- capture path ----------------
   logic [LEN_W-1:0] cap_n;
   logic [LEN_W-1:0] cap_len;
   logic [LEN_W:0]   cap_n_ext;
   logic [LEN_W:0]   cap_n1_ext;
   logic [SW-1:0]    cap_string;

   always_comb begin
      cap_n      = (rx_length > CAP_LEN) ? CAP_LEN : rx_length;
      cap_len    = (APPEND_CRLF != 0) ? cap_n + LEN_W'(2) : cap_n;
      cap_n_ext  = {1'b0, cap_n};
      cap_n1_ext = cap_n_ext + (LEN_W+1)'(1);
   end

   // Each byte is either transformed payload, the line ending, or zero fill.
   generate
      for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_byte
         localparam logic [LEN_W:0] IDX = (LEN_W+1)'(gi);
         assign cap_string[8*gi +: 8] =
            (IDX < cap_n_ext)                          ? case_convert(rx_string[8*gi +: 8], mode) :
            ((APPEND_CRLF != 0) && (IDX == cap_n_ext))  ? CHAR_CR :
            ((APPEND_CRLF != 0) && (IDX == cap_n1_ext)) ? CHAR_LF :
                                                          8'h00;
      end
   endgenerate

   // ---------------- queue ----------------
   logic               rx_valid;
   logic               q_full;
   logic               push;
   logic               pop;
   logic               drop;
   logic [ENTRY_W-1:0] head_entry;

   always_comb begin
      rx_valid = rx_done && (rx_length != '0);
      q_full   = (q_count == FULL_CNT);
      push     = rx_valid && (!q_full || pop);
      drop     = rx_valid && q_full && !pop;
   end

   uart_echo_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .push    (push),
      .pop     (pop),
      .wr_data ({cap_len, cap_string}),
      .rd_data (head_entry),
      .count   (q_count)
   );

   // ---------------- transmit FSM ----------------
   tx_state_t        state_q, state_d;
   logic [SW-1:0]    tx_string_q, tx_string_d;
   logic [LEN_W-1:0] tx_length_q, tx_length_d;
   logic             tx_req_q, tx_req_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             timeout_err_q, timeout_err_d;
   logic [7:0]       drop_cnt_q, drop_cnt_d;

   always_comb begin
      state_d       = state_q;
      tx_string_d   = tx_string_q;
      tx_length_d   = tx_length_q;
      tx_req_d      = 1'b0;
      timer_d       = timer_q;
      timeout_err_d = timeout_err_q;
      pop           = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if ((q_count != '0) && !tx_busy) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            tx_string_d = head_entry[SW-1:0];
            tx_length_d = head_entry[ENTRY_W-1:SW];
            tx_req_d    = 1'b1;
            state_d     = ST_REQ;
         end
         ST_REQ: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (tx_done) begin
               pop     = 1'b1;
               state_d = ST_IDLE;
            end else if (timer_q == TMR_LAST) begin
               pop           = 1'b1;
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q       <= ST_IDLE;
         tx_string_q   <= '0;
         tx_length_q   <= '0;
         tx_req_q      <= 1'b0;
         timer_q       <= '0;
         timeout_err_q <= 1'b0;
         drop_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         tx_string_q   <= tx_string_d;
         tx_length_q   <= tx_length_d;
         tx_req_q      <= tx_req_d;
         timer_q       <= timer_d;
         timeout_err_q <= timeout_err_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   assign tx_string   = tx_string_q;
   assign tx_length   = tx_length_q;
   assign tx_req      = tx_req_q;
   assign timeout_err = timeout_err_q;
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: doc/uart_echo_queue.md
Name: uart_echo_queue

Overview:
- Parametrised echo/response engine between the string receive and string transmit sides of the UART string handler.
- Captures each received string and applies a selectable case transform.
- Optionally appends "\r\n", queues up to DEPTH strings, and replays them one at a time through the transmit request/done handshake.
- Adds a transmit timeout with error reporting, and overflow drop counting.

Parameters:
- MAX_LEN, 128: maximum string length in bytes; string buses are MAX_LEN*8 bits wide.
- LEN_W, 8: width of length fields; must satisfy 2^LEN_W > MAX_LEN.
- DEPTH, 2: number of queued strings (power of 2, >=2).
- APPEND_CRLF, 1: 1 = append 8'h0D,8'h0A to every transmitted string.
- TIMEOUT_CYC, 50_000_000: cycles to wait for tx_done after tx_req before abandoning the string.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous, active-high reset
- mode  in  2  case transform: 00 pass, 01 upper, 10 lower, 11 swap case; sampled at capture
- rx_string  in  MAX_LEN*8  received string; byte i at [8i+7:8i], byte 0 first received
- rx_length  in  LEN_W  received byte count
- rx_done  in  1  one-cycle pulse, rx_string/rx_length valid this cycle
- tx_string  out  MAX_LEN*8  string to transmit, same byte order
- tx_length  out  LEN_W  byte count to transmit
- tx_req  out  1  one-cycle transmit request
- tx_busy  in  1  transmitter busy
- tx_done  in  1  one-cycle pulse, transmission finished
- q_count  out  $clog2(DEPTH)+1  strings currently queued
- drop_cnt  out  8  saturating count of strings dropped (queue full)
- timeout_err  out  1  sticky, set on any transmit timeout

Behaviour:
- Reset (sys_clk edge with sys_rst=1) clears all outputs and internal state to 0: tx_string, tx_length, tx_req, q_count, drop_cnt, timeout_err, pointers, FSM=IDLE. Reset mid-transmission abandons the string; queue contents are lost.
- Capture:
  - On an rx_done cycle with rx_length!=0, write a slot at the tail; it is visible in q_count on the next cycle.
  - rx_length==0 is ignored, with no count change.
  - Bytes at index >= rx_length are written as 0.
- Case transform, per byte, combinational before the write:
  - upper maps 8'h61..8'h7A minus 8'h20.
  - lower maps 8'h41..8'h5A plus 8'h20.
  - swap applies both; non-letters are unchanged.
- Length rule:
  - If APPEND_CRLF=0, L=min(rx_length,MAX_LEN).
  - If APPEND_CRLF=1, n=min(rx_length,MAX_LEN-2); bytes n and n+1 = 0D,0A; L=n+2.
- Full queue: if q_count==DEPTH on rx_done and no pop that cycle, drop the string; drop_cnt+1, saturating at 255.
- Simultaneous pop and rx_done: the capture is accepted; q_count is unchanged net.
- Tx FSM states IDLE, LOAD, REQ, WAIT:
  - IDLE: if q_count!=0 and tx_busy==0, go to LOAD.
  - LOAD: register the head slot into tx_string/tx_length; go to REQ.
  - REQ: tx_req=1 for exactly this cycle; clear the timer; go to WAIT.
  - WAIT: on tx_done, pop the head and go to IDLE. If the timer reaches TIMEOUT_CYC-1 without tx_done, pop the head, set timeout_err, and go to IDLE.
  - tx_done outside WAIT is ignored.
- Latency: with an empty queue and idle transmitter, rx_done at cycle N gives tx_req at cycle N+3. Capture occurs at N+1, IDLE→LOAD at N+2, and LOAD→REQ puts tx_req at N+3.
- tx_string/tx_length hold their value after tx_done until the next LOAD.
- Pointer wrap: head and tail are log2(DEPTH) bits and wrap naturally; q_count is tracked separately.

Decomposition:
- Package uart_echo_pkg: mode encodings (MODE_PASS/UPPER/LOWER/SWAP), CR/LF constants, FSM state enum, case-convert function.
- Sub-module uart_echo_fifo: DEPTH x (MAX_LEN*8+LEN_W) storage with push/pop/count; the top holds the FSM, transform and timer.
- Instantiate with uart_string_handle's tx/rx ports wired directly.

Test Plan:
- rx "abc" (len 3), mode=01, APPEND_CRLF=1 -> tx_req at N+3, tx_length=5, bytes 41,42,43,0D,0A; hold tx_busy for 20 cycles then pulse tx_done -> q_count returns to 0.
- rx len 128, APPEND_CRLF=1 -> tx_length=128, bytes 126/127 = 0D/0A, byte 125 = original byte 125.
- Push 3 strings while tx_busy=1 held (DEPTH=2) -> q_count=2, drop_cnt=1, and the two survivors transmit in arrival order.
- rx_done coincident with tx_done pop on a full queue -> no drop, q_count stays 2.
- TIMEOUT_CYC=100, tx_done never pulsed -> timeout_err=1 at tx_req+100 cycles, head popped, next string requested.
- sys_rst asserted during WAIT -> all outputs 0 next cycle; a late tx_done is ignored; rx_length=0 pulses never change q_count.
